regfile_mp: RTL

//  Parametrised multi-port register file for the pipelined MIPS core: NRD combinational read ports, NWR

---
 rtl/regfile_pkg.sv | 31 +++
 rtl/regfile_mp_if.sv | 34 +++
 rtl/regfile_rd_port.sv | 56 +++++
 rtl/regfile_mp.sv | 107 ++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and write-port priority helpers for the multi-port register file.
// Pure declarations, no state: everything here is evaluated combinationally.
// No handshake involved; callers use these functions inside their own logic.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  // Widest write-port count the priority helpers handle.
  localparam int MAX_WR = 8;

  // Keep only the highest set bit: a higher write port index has priority.
  function automatic logic [MAX_WR-1:0] onehot_hi_prio(input logic [MAX_WR-1:0] req);
    logic [MAX_WR-1:0] sel;
    sel = '0;
    for (int k = MAX_WR - 1; k >= 0; k--) begin
      if (req[k] && (sel == '0)) sel[k] = 1'b1;
    end
    return sel;
  endfunction

  // Position of the set bit of a one-hot vector; 0 when the vector is empty.
  function automatic int pack_idx(input logic [MAX_WR-1:0] onehot);
    int idx;
    idx = 0;
    for (int k = 0; k < MAX_WR; k++) begin
      if (onehot[k]) idx = k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bundle of write, read and scoreboard signals between the pipeline and the register file.
// Carries no state; read data and busy flags are combinational functions of the inputs.
// No backpressure: the register file accepts every write, read and set each cycle.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);
  logic [NWR-1:0]        we;
  logic [NWR*ADDR_W-1:0] waddr;
  logic [NWR*DATA_W-1:0] wdata;
  logic [NRD-1:0]        re;
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;
  logic                  sb_set;
  logic [ADDR_W-1:0]     sb_addr;
  logic [ADDR_W:0]       busy_cnt;

  // Pipeline side: issues writes, reads and scoreboard sets.
  modport master (
    output we, waddr, wdata, re, raddr, sb_set, sb_addr,
    input  rdata, rbusy, busy_cnt
  );

  // Register file side.
  modport slave (
    input  we, waddr, wdata, re, raddr, sb_set, sb_addr,
    output rdata, rbusy, busy_cnt
  );
endinterface

// File: rtl/regfile_rd_port.sv
// One read port: enable/zero-register gating, same-cycle write forwarding and operand-busy flag.
// Zero latency: purely combinational from address, in-flight writes and stored state.
// No backpressure: rbusy only reports a pending producer, it never stalls this port.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  rst,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0]     reg_data,
  input  logic                  pend,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rbusy
);

  logic [MAX_WR-1:0] hit_vec;
  logic [MAX_WR-1:0] hit_sel;
  logic              fwd_hit;
  logic              is_zero;
  int                fwd_idx;

  // Compare this port's address with every write in flight and pick the highest-index match.
  always_comb begin
    hit_vec = '0;
    for (int k = 0; k < NWR; k++) begin
      hit_vec[k] = we[k] && (waddr[k*ADDR_W +: ADDR_W] == raddr);
    end
    hit_sel = onehot_hi_prio(hit_vec);
    fwd_idx = pack_idx(hit_sel);
    fwd_hit = |hit_vec;
    is_zero = (ZERO_REG != 0) && (raddr == '0);
  end

  // Read mux: gated by reset and own enable, then zero register, then forwarding, then storage.
  always_comb begin
    rdata = '0;
    rbusy = 1'b0;
    if (rst && re && !is_zero) begin
      rdata = reg_data;
      for (int k = 0; k < NWR; k++) begin
        if (fwd_hit && (k == fwd_idx)) rdata = wdata[k*DATA_W +: DATA_W];
      end
      // A write landing this cycle satisfies the pending operand.
      rbusy = pend && !fwd_hit;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-priority merge, per-read-port forwarding and pending scoreboard.
// Reads are combinational; writes and scoreboard updates land on the next rising clk edge.
// No backpressure: every write and sb_set is accepted; rbusy tells decode an operand is not ready.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs    [DEPTH];
  logic [DATA_W-1:0] wr_data [DEPTH];
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  sb_hit;
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_nxt;
  logic [CNT_W-1:0]  busy_cnt_q;
  logic [CNT_W-1:0]  cnt_rise;
  logic [CNT_W-1:0]  cnt_fall;

  // Per register: is it written this cycle, and by which port (highest index wins).
  always_comb begin
    logic [MAX_WR-1:0] req;
    int                win;
    for (int a = 0; a < DEPTH; a++) begin
      req = '0;
      for (int k = 0; k < NWR; k++) begin
        req[k] = bus.we[k] && (bus.waddr[k*ADDR_W +: ADDR_W] == ADDR_W'(a));
      end
      win        = pack_idx(onehot_hi_prio(req));
      wr_hit[a]  = (|req) && !((ZERO_REG != 0) && (a == 0));
      wr_data[a] = '0;
      for (int k = 0; k < NWR; k++) begin
        if (k == win) wr_data[a] = bus.wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Scoreboard next state: writes clear, sb_set sets and wins on the same register; count the deltas.
  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
      sb_hit[a] = bus.sb_set && (bus.sb_addr == ADDR_W'(a)) && !((ZERO_REG != 0) && (a == 0));
    end
    pending_nxt = (pending & ~wr_hit) | sb_hit;
    cnt_rise    = '0;
    cnt_fall    = '0;
    for (int a = 0; a < DEPTH; a++) begin
      cnt_rise = cnt_rise + CNT_W'(pending_nxt[a] & ~pending[a]);
      cnt_fall = cnt_fall + CNT_W'(pending[a] & ~pending_nxt[a]);
    end
  end

  // Storage array: synchronous clear, otherwise commit the winning write per register.
  always_ff @(posedge clk) begin
    for (int a = 0; a < DEPTH; a++) begin
      if (!rst) regs[a] <= '0;
      else if (wr_hit[a]) regs[a] <= wr_data[a];
    end
  end

  // Pending bits and their running popcount, updated from this cycle's set/clear deltas.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending    <= '0;
      busy_cnt_q <= '0;
    end else begin
      pending    <= pending_nxt;
      busy_cnt_q <= busy_cnt_q + cnt_rise - cnt_fall;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = bus.raddr[i*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NWR     (NWR),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .rst     (rst),
      .re      (bus.re[i]),
      .raddr   (ra),
      .we      (bus.we),
      .waddr   (bus.waddr),
      .wdata   (bus.wdata),
      .reg_data(regs[ra]),
      .pend    (pending[ra]),
      .rdata   (bus.rdata[i*DATA_W +: DATA_W]),
      .rbusy   (bus.rbusy[i])
    );
  end

endmodule
